// File: rtl/multdiv_unit.sv
// multdiv_unit
//   Iterative signed multiply/divide unit for the execute stage. Multiply is
//   radix-2 shift-add and divide is restoring. Both work on operand
//   magnitudes, retire one bit per cycle, and apply the sign on a final
//   fix-up edge.
//
//   Handshake: ctrl_MULT / ctrl_DIV are single-cycle start pulses. They are
//   accepted in IDLE and DONE and ignored in BUSY. If both are high, MULT
//   wins. data_resultRDY pulses for one cycle when data_result and
//   data_exception are updated. Both outputs hold until the next completion.
//
// Ports
//   clock, reset    rising-edge clock; asynchronous active-high reset
//   ctrl_MULT       start A*B
//   ctrl_DIV        start A/B
//   data_operandA   multiplicand / dividend (two's complement)
//   data_operandB   multiplier / divisor (two's complement)
//   data_result     low WIDTH bits of the product, or the quotient
//   data_exception  overflow or divide-by-zero for this result
//   data_resultRDY  one-cycle completion pulse
//   dbg_state       current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             start, last, is_div, sign, dz;
  logic [WIDTH-1:0] acc_hi, acc_lo, mag_b;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] prod_mag, prod_sgn;
  logic [WIDTH-1:0]   quo_sgn, fix_result;
  logic               fix_exc;

  assign dbg_state = state;

  // Next-state logic.
  always_comb begin
    start     = (ctrl_MULT || ctrl_DIV) && (state != BUSY);
    last      = (cnt == CW'(WIDTH));
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath arithmetic.
  always_comb begin
    a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Shift-add step. The multiplier bits sit in acc_lo and are consumed
    // LSB first, while the partial product shifts in from the top.
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);

    // Restoring step. The remainder is always below the divisor, so it
    // fits in WIDTH bits. The trial subtraction needs one extra bit.
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, mag_b};

    // Sign fix-up.
    prod_mag = {acc_hi, acc_lo};
    prod_sgn = sign ? -prod_mag : prod_mag;
    quo_sgn  = sign ? -acc_lo : acc_lo;

    fix_result = '0;
    fix_exc    = 1'b0;
    if (is_div) begin
      fix_result = dz ? '0 : quo_sgn;
      // A positive quotient with the MSB set can only come from
      // -2^(W-1) / -1.
      fix_exc = dz || (!sign && acc_lo[WIDTH-1]);
    end else begin
      fix_result = prod_sgn[WIDTH-1:0];
      fix_exc    = !((&prod_sgn[2*WIDTH-1:WIDTH-1]) ||
                     !(|prod_sgn[2*WIDTH-1:WIDTH-1]));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      is_div         <= 1'b0;
      sign           <= 1'b0;
      dz             <= 1'b0;
      acc_hi         <= '0;
      acc_lo         <= '0;
      mag_b          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state          <= state_nxt;
      data_resultRDY <= 1'b0;
      if (start) begin
        is_div <= !ctrl_MULT;
        sign   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dz     <= !ctrl_MULT && (data_operandB == '0);
        mag_b  <= b_mag;
        acc_hi <= '0;
        acc_lo <= a_mag;
        // A zero divisor needs no iterations. Preloading the count makes
        // the very next edge the completion edge.
        cnt    <= (!ctrl_MULT && (data_operandB == '0)) ? CW'(WIDTH) : '0;
      end else if (state == BUSY) begin
        if (last) begin
          data_result    <= fix_result;
          data_exception <= fix_exc;
          data_resultRDY <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            acc_hi <= div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], !div_trial[WIDTH]};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
module tb_multdiv_unit;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ctrl_MULT = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic [1:0]   dbg_state;

  multdiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic         exc_q[$];
  int           due_q[$];
  logic [W-1:0] hold_res = '0;
  logic         hold_exc = 1'b0;
  bit           chk_en = 1'b0;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain signed 64-bit arithmetic.
  task automatic model(input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic exc, output int lat);
    longint p;
    int q;
    lat = 33;
    if (is_mult) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      res = p[W-1:0];
      exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == '0) begin
      res = '0; exc = 1'b1; lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000; exc = 1'b1;
    end else begin
      q   = $signed(a) / $signed(b);
      res = q; exc = 1'b0;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      if (data_resultRDY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rdy", 32'd1, 32'd0);
        end else begin
          check("rdy_cycle", cyc, due_q[0]);
          check("result", data_result, exp_q[0]);
          check("exception", {31'd0, data_exception}, {31'd0, exc_q[0]});
          hold_res = exp_q[0];
          hold_exc = exc_q[0];
          void'(exp_q.pop_front()); void'(exc_q.pop_front()); void'(due_q.pop_front());
        end
      end else begin
        if (exp_q.size() != 0 && due_q[0] <= cyc) begin
          check("missing_rdy", 32'd0, 32'd1);
          void'(exp_q.pop_front()); void'(exc_q.pop_front()); void'(due_q.pop_front());
        end
        check("hold_result", data_result, hold_res);
        check("hold_exception", {31'd0, data_exception}, {31'd0, hold_exc});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge. Drives a one-cycle start pulse and queues the model
  // result. Operands are scrambled after capture so late sampling shows up.
  task automatic start_op(input bit mult, input bit div, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] lit_res,
                          input logic lit_exc, input string name);
    logic [W-1:0] r; logic e; int lat; int k;
    model(mult, a, b, r, e, lat);
    check({name, "_model_res"}, r, lit_res);
    check({name, "_model_exc"}, {31'd0, e}, {31'd0, lit_exc});
    ctrl_MULT = mult; ctrl_DIV = div;
    data_operandA = a; data_operandB = b;
    @(posedge clock); #1;
    k = cyc;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
    exp_q.push_back(r); exc_q.push_back(e); due_q.push_back(k + lat);
  endtask

  // Returns at the negedge on which RDY is seen, within a cycle budget.
  task automatic wait_rdy();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (data_resultRDY) seen = 1'b1;
    end
    if (!seen) check("rdy_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input bit mult, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] lit_res, input logic lit_exc, input string name);
    @(negedge clock);
    start_op(mult, !mult, a, b, lit_res, lit_exc, name);
    wait_rdy();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clock);
    check("reset_result", data_result, 32'd0);
    check("reset_exc", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    run(1, 32'd7, 32'd6, 32'd42, 1'b0, "mul_7x6");
    run(1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, "mul_m3x5");
    run(1, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, "mul_ovf");
    run(1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'd42, 1'b0, "mul_m7xm6");
    run(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "mul_min_m1");
    run(1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, "mul_min_1");
    run(1, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, "mul_max_2");
    run(0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
    run(0, 32'd100, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0, "div_100_m10");
    run(0, 32'd5, 32'd0, 32'd0, 1'b1, "div_by_zero");
    run(0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
    run(0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, "div_min_1");
    run(0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "div_7_m2");
    run(0, 32'd0, 32'd5, 32'd0, 1'b0, "div_0_5");

    // Both starts high: MULT wins.
    @(negedge clock);
    start_op(1, 1, 32'd9, 32'd3, 32'd27, 1'b0, "both_start");
    wait_rdy();

    // A DIV pulse in the middle of a MULT is ignored.
    @(negedge clock);
    start_op(1, 0, 32'd123, 32'hFFFF_FFFE, 32'hFFFF_FF0A, 1'b0, "mul_busy_pulse");
    repeat (5) @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd50; data_operandB = 32'd0;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    wait_rdy();

    // Back-to-back: start on the RDY cycle itself, including after a divide by zero.
    start_op(1, 0, 32'd11, 32'd11, 32'd121, 1'b0, "b2b_1");
    wait_rdy();
    start_op(0, 1, 32'd77, 32'd0, 32'd0, 1'b1, "b2b_dz");
    wait_rdy();
    start_op(0, 1, 32'd1000, 32'd7, 32'd142, 1'b0, "b2b_2");
    wait_rdy();

    // Reset at iteration 10 aborts the op; outputs clear asynchronously.
    @(negedge clock);
    start_op(1, 0, 32'd3, 32'd3, 32'd9, 1'b0, "mul_aborted");
    repeat (9) @(posedge clock);
    #3;
    reset = 1'b1;
    exp_q.delete(); exc_q.delete(); due_q.delete();
    hold_res = '0; hold_exc = 1'b0;
    #1;
    check("async_reset_result", data_result, 32'd0);
    check("async_reset_exc", {31'd0, data_exception}, 32'd0);
    check("async_reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    // Any RDY from the aborted op would now be flagged as unexpected.
    repeat (40) @(negedge clock);

    run(1, 32'd1, 32'd1, 32'd1, 1'b0, "mul_after_reset");

    repeat (3) @(negedge clock);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    n_bad++;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
